mem_access_arbiter: RTL
=======================

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter `WAIT_CYCLES`, default 1: memory read latency in clocks, legal range 1..4.
REQ-002 SHALL have port `Clock`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port `Reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `f_req`, input, 1 bit: instruction-fetch request.
REQ-005 SHALL have port `f_addr`, input, 16 bits: fetch byte address; fetch is always a word read.
REQ-006 SHALL have port `f_ack`, output, 1 bit: fetch done, one-cycle pulse.
REQ-007 SHALL have ports for the data (load/store) requester:
- `d_req`, input, 1 bit.
- `d_we`, input, 1 bit: 1 = write.
- `d_byte`, input, 1 bit: 1 = byte access, 0 = word access.
- `d_addr`, input, 16 bits.
- `d_wdata`, input, 16 bits.
REQ-008 SHALL have port `d_ack`, output, 1 bit: data access done, one-cycle pulse.
REQ-009 SHALL have ports for the debug viewer:
- `g_req`, input, 1 bit.
- `g_addr`, input, 16 bits: word read.
- `g_ack`, output, 1 bit.
REQ-010 SHALL have port `rdata`, output, 16 bits: read result, valid in the cycle the ack is high.
REQ-011 SHALL have port `err`, output, 1 bit: misaligned access, valid with the ack.
REQ-012 SHALL have port `grant`, output, 2 bits: 0 none, 1 fetch, 2 data, 3 debug.
REQ-013 SHALL have memory-side ports:
- `mem_addr`, output, 16 bits.
- `mem_wdata`, output, 16 bits.
- `mem_we`, output, 1 bit.
- `mem_byte`, output, 1 bit.
- `mem_rdata`, input, 16 bits.

Function
REQ-014 SHALL implement FSM states IDLE → ACCESS → RESP → IDLE.
REQ-015 In IDLE, SHALL sample requests and pick one winner:
- Data vs fetch: round-robin; the pointer toggles after each fetch or data grant.
- Debug: granted only when `f_req` = `d_req` = 0.
REQ-016 SHALL register the winner's address, control and write data at the IDLE→ACCESS edge. `grant` shows the winner from ACCESS through RESP.
REQ-017 SHALL stay in ACCESS for exactly `WAIT_CYCLES` cycles.
- `mem_addr` and `mem_byte` are held stable throughout.
- `mem_we` is high only in the first ACCESS cycle, and only for a write.
REQ-018 SHALL capture `mem_rdata` at the end of the last ACCESS cycle.
- In RESP, the winner's ack is high for exactly one cycle, then the FSM returns to IDLE.
- Ack therefore rises `WAIT_CYCLES`+1 cycles after the sampling edge.
REQ-019 Word accesses: SHALL force `mem_addr[0]` to 0.
REQ-020 If a word address has bit 0 = 1, SHALL skip ACCESS (IDLE→RESP) and pulse ack with `err` = 1, `rdata` = 0, and no memory write.
REQ-021 Byte read: `rdata` = {8'h00, selected byte}; the high byte is selected when `addr[0]` = 1.
REQ-022 Byte write: `mem_wdata` = {`d_wdata[7:0]`, `d_wdata[7:0]`} with `mem_byte` = 1.
REQ-023 Requesters drop `req` in the cycle after ack.
- A request still high when IDLE is re-entered is treated as a new request.
- At least one IDLE cycle separates transactions.
REQ-024 Request inputs that change during ACCESS or RESP SHALL NOT affect the current transaction.
REQ-025 When not in RESP, `rdata` and `err` SHALL be 0. When not in ACCESS, all `mem_*` outputs SHALL be 0.

Reset
REQ-026 On `Reset_n` = 0, SHALL immediately (asynchronously) force state IDLE and clear the following:
- all acks, `grant`, `err`, `rdata`, and all `mem_*` outputs;
- the round-robin pointer, set so that fetch is favoured first.
REQ-027 A reset during ACCESS or RESP SHALL abort the transaction with no ack issued. Any `mem_we` pulse already issued stands.

Structure
REQ-028 Shared package `xm23_pkg` SHALL hold the following; no literals are duplicated in RTL:
- the FSM state enum;
- grant codes `GNT_NONE`, `GNT_FETCH`, `GNT_DATA`, `GNT_DEBUG`;
- the `WAIT_CYCLES` range limits.
REQ-029 The winner-selection logic SHALL be one sub-module, `mem_rr_pick`: combinational, taking the requests and pointer and returning a grant code. The FSM, counters and registers stay in `mem_access_arbiter`.

Verification
REQ-030 Single fetch: `f_req` = 1, `f_addr` = 16'h0010, `mem_rdata` = 16'h4C08, `WAIT_CYCLES` = 1 → `f_ack` 2 cycles after sampling, `rdata` = 16'h4C08, `grant` = 1, `mem_addr` = 16'h0010.
REQ-031 Simultaneous requests: `f_req` and `d_req` held high after reset → served in order fetch, data, fetch, data; `g_req` held high throughout is never granted.
REQ-032 Byte store: `d_we` = 1, `d_byte` = 1, `d_addr` = 16'h0101, `d_wdata` = 16'h12AB → one cycle with `mem_we` = 1, `mem_byte` = 1, `mem_wdata` = 16'hABAB, `mem_addr` = 16'h0101.
REQ-033 Misaligned word load: `d_addr` = 16'h0003 → `d_ack` 1 cycle after sampling, `err` = 1, `rdata` = 0, `mem_we` never asserted.
REQ-034 `Reset_n` pulsed low during ACCESS with `WAIT_CYCLES` = 3 → outputs 0 at once, no ack; the next request completes normally.
REQ-035 Byte read: `d_addr` = 16'h0021, `mem_rdata` = 16'h7F05 → `rdata` = 16'h007F.

Source files
------------

// File: rtl/xm23_pkg.sv
// xm23_pkg
// Shared definitions for the memory access arbiter:
//   state_t        - arbiter FSM states
//   grant_t        - requester grant codes (GNT_NONE/FETCH/DATA/DEBUG)
//   WAIT_MIN/MAX   - legal range of the memory read latency parameter
//   is_misaligned  - word access with odd byte address
package xm23_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE  = 2'd0;
  localparam grant_t GNT_FETCH = 2'd1;
  localparam grant_t GNT_DATA  = 2'd2;
  localparam grant_t GNT_DEBUG = 2'd3;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 4;

  function automatic logic is_misaligned(input logic byte_acc, input logic [15:0] addr);
    return !byte_acc && addr[0];
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick
// Combinational winner selection for the memory arbiter.
// Ports:
//   f_req, d_req, g_req - fetch, data and debug requests
//   rr_ptr              - round-robin pointer (0 favours fetch, 1 favours data)
//   pick                - grant code of the winner, GNT_NONE if no request
module mem_rr_pick
  import xm23_pkg::*;
(
  input  logic   f_req,
  input  logic   d_req,
  input  logic   g_req,
  input  logic   rr_ptr,
  output grant_t pick
);

  // Fetch and data share the round-robin; debug only wins when both are quiet.
  always_comb begin
    pick = GNT_NONE;
    if (f_req && d_req) begin
      pick = rr_ptr ? GNT_DATA : GNT_FETCH;
    end else if (f_req) begin
      pick = GNT_FETCH;
    end else if (d_req) begin
      pick = GNT_DATA;
    end else if (g_req) begin
      pick = GNT_DEBUG;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Three-requester arbiter (instruction fetch, load/store data, debug viewer)
// in front of a single-port 16-bit memory with WAIT_CYCLES read latency.
// Ports:
//   Clock, Reset_n                      - clock, async active-low reset
//   f_req/f_addr/f_ack                  - fetch requester (word reads)
//   d_req/d_we/d_byte/d_addr/d_wdata/d_ack - data requester
//   g_req/g_addr/g_ack                  - debug requester (word reads)
//   rdata, err                          - response, valid with the ack
//   grant                               - current winner from ACCESS through RESP
//   mem_addr/mem_wdata/mem_we/mem_byte/mem_rdata - memory side
module mem_access_arbiter
  import xm23_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  input  logic        g_req,
  input  logic [15:0] g_addr,
  output logic        g_ack,
  output logic [15:0] rdata,
  output logic        err,
  output grant_t      grant,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_byte,
  input  logic [15:0] mem_rdata
);

  // Out-of-range parameter values are clamped into the legal latency window.
  localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                            (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [1:0] LAST_CNT = 2'(WAIT_EFF - 1);

  state_t      state, state_next;
  logic [1:0]  cnt;
  logic        rr_ptr;
  grant_t      pick;
  grant_t      cur_gnt;
  logic [15:0] cur_addr;
  logic [15:0] cur_wdata;
  logic        cur_we;
  logic        cur_byte;
  logic        cur_err;
  logic [15:0] cap_rdata;

  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_we;
  logic        sel_byte;
  logic        sel_bad;

  mem_rr_pick u_pick (
    .f_req  (f_req),
    .d_req  (d_req),
    .g_req  (g_req),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // Route the winner's request fields; byte stores replicate the low byte.
  always_comb begin
    sel_addr  = 16'h0000;
    sel_wdata = 16'h0000;
    sel_we    = 1'b0;
    sel_byte  = 1'b0;
    case (pick)
      GNT_FETCH: sel_addr = f_addr;
      GNT_DATA: begin
        sel_addr  = d_addr;
        sel_we    = d_we;
        sel_byte  = d_byte;
        sel_wdata = d_byte ? {d_wdata[7:0], d_wdata[7:0]} : d_wdata;
      end
      GNT_DEBUG: sel_addr = g_addr;
      default: sel_addr = 16'h0000;
    endcase
    sel_bad = is_misaligned(sel_byte, sel_addr);
  end

  // Misaligned word accesses go straight to RESP so memory is never touched.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          state_next = sel_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == LAST_CNT) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The request is latched at the IDLE exit so later input changes are ignored.
  // Word addresses are stored with bit 0 cleared; byte addresses keep it for lane select.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      rr_ptr    <= 1'b0;
      cur_gnt   <= GNT_NONE;
      cur_addr  <= 16'h0000;
      cur_wdata <= 16'h0000;
      cur_we    <= 1'b0;
      cur_byte  <= 1'b0;
      cur_err   <= 1'b0;
      cap_rdata <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && pick != GNT_NONE) begin
        cur_gnt   <= pick;
        cur_addr  <= sel_byte ? sel_addr : {sel_addr[15:1], 1'b0};
        cur_wdata <= sel_wdata;
        cur_we    <= sel_we;
        cur_byte  <= sel_byte;
        cur_err   <= sel_bad;
        cnt       <= 2'd0;
        if (pick != GNT_DEBUG) begin
          rr_ptr <= ~rr_ptr;
        end
      end
      if (state == ST_ACCESS) begin
        cnt <= cnt + 2'd1;
        if (cnt == LAST_CNT) begin
          if (cur_we) begin
            cap_rdata <= 16'h0000;
          end else if (cur_byte) begin
            cap_rdata <= cur_addr[0] ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
          end else begin
            cap_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  // All outputs decode from registered state, so reset clears them immediately.
  always_comb begin
    grant     = GNT_NONE;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    g_ack     = 1'b0;
    rdata     = 16'h0000;
    err       = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    case (state)
      ST_ACCESS: begin
        grant     = cur_gnt;
        mem_addr  = cur_addr;
        mem_wdata = cur_wdata;
        mem_byte  = cur_byte;
        mem_we    = cur_we && (cnt == 2'd0);
      end
      ST_RESP: begin
        grant = cur_gnt;
        err   = cur_err;
        rdata = cur_err ? 16'h0000 : cap_rdata;
        f_ack = (cur_gnt == GNT_FETCH);
        d_ack = (cur_gnt == GNT_DATA);
        g_ack = (cur_gnt == GNT_DEBUG);
      end
      default: grant = GNT_NONE;
    endcase
  end

endmodule
